// File: rtl/memi_pipe.sv
// memi_pipe: pipelined instruction memory for the fetch stage.
//
// A hardware init sequence fills the array with INIT_WORD. After that the
// block accepts one fetch request per cycle and returns FETCH_W consecutive
// words, wrapping around the end of the array. Each response appears LATENCY
// cycles after the request is accepted.
//
// State table:
//   state    | meaning
//   ST_INIT  | writing INIT_WORD to mem[cnt]; requests and load writes blocked
//   ST_READY | serving fetch requests and program-load writes
//
// Ports:
//   clk_i, rst_n_i      clock (rising edge); asynchronous active-low reset
//   clear_i             re-enter init and refill the array with INIT_WORD
//   flush_i             drop every in-flight read response
//   req_valid_i/_ready_o, req_addr_i   fetch request handshake and start index
//   resp_valid_o, resp_data_o          one-cycle response; word i at [i*INST_LEN +: INST_LEN]
//   wr_en_i, wr_addr_i, wr_data_i      program-load write port (READY only)
//   init_done_o         high while in ST_READY
module memi_pipe #(
  parameter int                INST_LEN  = 16,
  parameter int                DEPTH     = 8,
  parameter int                ADDR_W    = $clog2(DEPTH),
  parameter int                FETCH_W   = 2,
  parameter int                LATENCY   = 1,
  parameter logic [INST_LEN-1:0] INIT_WORD = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        clear_i,
  input  logic                        flush_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [ADDR_W-1:0]           req_addr_i,
  output logic                        resp_valid_o,
  output logic [FETCH_W*INST_LEN-1:0] resp_data_o,
  input  logic                        wr_en_i,
  input  logic [ADDR_W-1:0]           wr_addr_i,
  input  logic [INST_LEN-1:0]         wr_data_i,
  output logic                        init_done_o
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                      state_q, state_d;
  logic [ADDR_W-1:0]           cnt_q, cnt_d;
  logic [INST_LEN-1:0]         mem_q [DEPTH];
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_waddr;
  logic [INST_LEN-1:0]         mem_wdata;
  logic                        accept;
  logic                        kill;
  logic [FETCH_W*INST_LEN-1:0] rd_data;
  logic [LATENCY-1:0]          vld_q, vld_d;
  logic [FETCH_W*INST_LEN-1:0] dat_q [LATENCY];
  logic [FETCH_W*INST_LEN-1:0] dat_d [LATENCY];

  assign req_ready_o  = (state_q == ST_READY);
  assign init_done_o  = (state_q == ST_READY);
  assign accept       = req_valid_i && req_ready_o;
  // clear drops in-flight reads exactly like flush
  assign kill         = flush_i || clear_i;
  assign resp_valid_o = vld_q[LATENCY-1];
  assign resp_data_o  = dat_q[LATENCY-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr_i;
    mem_wdata = wr_data_i;
    unique case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = INIT_WORD;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        mem_we = wr_en_i && !clear_i;
      end
      default: state_d = ST_INIT;
    endcase
    if (clear_i) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array is not reset; the init sequence rewrites every entry.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Combinational read sees the array before this edge's write, so a
  // same-edge write to an overlapping index returns old data. The ADDR_W-bit
  // sum wraps naturally because DEPTH is a power of two.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      rd_data[i*INST_LEN +: INST_LEN] = mem_q[req_addr_i + ADDR_W'(i)];
    end
  end

  // Data registers only load alongside a valid bit, so the output stage
  // holds its last response while resp_valid is low.
  always_comb begin
    vld_d[0] = accept && !kill;
    dat_d[0] = vld_d[0] ? rd_data : dat_q[0];
    for (int k = 1; k < LATENCY; k++) begin
      vld_d[k] = vld_q[k-1] && !kill;
      dat_d[k] = vld_d[k] ? dat_q[k-1] : dat_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) dat_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < LATENCY; k++) dat_q[k] <= dat_d[k];
    end
  end

endmodule

// File: tb/tb_memi_pipe.sv
module tb_memi_pipe;

  localparam int LAT = 3;

  logic        clk, rst_n, clear, flush;
  logic        req_valid, req_ready;
  logic [2:0]  req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        init_done;

  memi_pipe #(
    .INST_LEN(16), .DEPTH(8), .FETCH_W(2), .LATENCY(LAT), .INIT_WORD(16'h0000)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .init_done_o(init_done)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [8];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          resp_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (resp_valid) begin
        resp_seen++;
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_data", resp_data, e.data);
          check("resp_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("missing_resp", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    req_valid = 1'b0;
    wr_en     = 1'b0;
    clear     = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic issue(input logic [2:0] a, input bit expect_resp);
    exp_t e;
    req_valid = 1'b1;
    req_addr  = a;
    if (expect_resp) begin
      e.data = {model[a + 3'd1], model[a]};
      e.due  = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    model[a] = d;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 30) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    tick();
  endtask

  task automatic count_init(input string name);
    int n = 0;
    while (!req_ready && n < 20) begin
      n++;
      if (n >= 2) begin
        // index 0 was already refilled; an honoured write would survive
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 16'hBEEF;
      end
      tick();
    end
    check(name, 32'(n), 32'd8);
    check({name, "_done"}, {31'd0, init_done}, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    rst_n = 1'b0; clear = 1'b0; flush = 1'b0; req_valid = 1'b0;
    req_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    tick(); tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);

    rst_n = 1'b1;
    count_init("init_cycles");

    issue(3'd0, 1); tick();
    issue(3'd5, 1); tick();
    drain();

    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 16'(16'h1111 * (i + 1)));
      tick();
    end
    issue(3'd6, 1); tick(); drain();
    issue(3'd7, 1); tick(); drain();
    check("wrap_model", {model[0], model[7]}, 32'h1111_8888);

    issue(3'd0, 1); tick();
    issue(3'd2, 1); tick();
    issue(3'd4, 1); tick();
    drain();

    issue(3'd3, 1);
    wr(3'd3, 16'hABCD);
    tick(); drain();
    issue(3'd3, 1); tick(); drain();

    s0 = resp_seen;
    issue(3'd1, 0); tick();
    issue(3'd2, 0); tick();
    issue(3'd6, 0); flush = 1'b1; tick();
    issue(3'd5, 1); tick();
    drain(); tick(); tick(); tick();
    check("flush_resp_count", 32'(resp_seen - s0), 32'd1);

    s0 = resp_seen;
    issue(3'd0, 0); tick();
    clear = 1'b1; tick();
    check("clear_ready_drop", {31'd0, req_ready}, 32'd0);
    check("clear_done_drop", {31'd0, init_done}, 32'd0);
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    count_init("clear_init_cycles");
    tick(); tick();
    check("clear_resp_count", 32'(resp_seen - s0), 32'd0);
    issue(3'd0, 1); tick();
    issue(3'd2, 1); tick();
    issue(3'd4, 1); tick();
    issue(3'd6, 1); tick();
    drain();

    wr(3'd1, 16'h5A5A); tick();
    issue(3'd1, 1); tick();
    n = 0;
    while (!resp_valid && n < 10) begin
      tick();
      n++;
    end
    check("async_wait_valid", {31'd0, resp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("async_resp_data", resp_data, 32'd0);
    check("async_req_ready", {31'd0, req_ready}, 32'd0);
    check("async_init_done", {31'd0, init_done}, 32'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memi_pipe.md
Name: memi_pipe

Overview:
Parametrised next-generation instruction memory for the OOO core's fetch stage. Adds features the single-port combinational instruction store lacks:
- valid/ready request port with configurable pipeline read latency
- multi-instruction fetch per request, with wrap-around addressing
- program-load write port
- flush of in-flight reads on a squash
- sequential hardware init/clear state machine

Parameters:
INST_LEN, 16, width of one instruction word in bits
DEPTH, 8, number of instruction entries; power of two, at least 4
ADDR_W, log2(DEPTH), address width
FETCH_W, 2, instructions returned per request (1..4)
LATENCY, 1, cycles from request acceptance to response (1..4)
INIT_WORD, 0, value written to every entry during init/clear

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; one clock, asynchronous assert, active-low
clear  in  1  pulse: re-enter INIT and refill the array with INIT_WORD
flush  in  1  drop all in-flight read responses
req_valid  in  1  fetch request valid
req_ready  out  1  memory can accept a request
req_addr  in  ADDR_W  first instruction index of the fetch
resp_valid  out  1  response valid for exactly one cycle
resp_data  out  FETCH_W*INST_LEN  fetched words; word i at bits [i*INST_LEN +: INST_LEN]
wr_en  in  1  program-load write strobe
wr_addr  in  ADDR_W  write index
wr_data  in  INST_LEN  write value
init_done  out  1  high while in READY

Behaviour:
- Reset (rst_n low, async): state=INIT, init counter=0, all pipeline valid bits=0.
  - Output values during reset: resp_valid=0, resp_data=0, req_ready=0, init_done=0.
  - Array contents are not reset directly; the init FSM rewrites them.
- States:
  - INIT: each cycle writes INIT_WORD to array[cnt], then cnt++. On the edge that writes cnt=DEPTH-1, go to READY. INIT therefore lasts exactly DEPTH cycles after rst_n rises.
  - READY: req_ready=1 and init_done=1. clear=1 goes to INIT with cnt=0.
- Request acceptance: a request is accepted at a rising edge where req_valid && req_ready.
  - Data is read from the array contents before any write on that same edge: a same-cycle write to an overlapping address returns old data.
  - Word i of the response = array[(req_addr+i) mod DEPTH]. Wrap-around is silent.
- Latency and throughput:
  - Response for a request accepted at edge t is presented (resp_valid=1 with resp_data) in the cycle after edge t+LATENCY-1. LATENCY=1 means the response is visible in the cycle right after acceptance.
  - Full throughput: one request per cycle. No response backpressure.
- resp_data when resp_valid=0: holds its last value (0 after reset). Benches must not check it.
- Writes: wr_en is honoured only in READY and only when clear=0. It is ignored in INIT. The effect is visible to requests accepted on later edges.
- flush: on an edge with flush=1, every pipeline valid bit is cleared.
  - A request accepted on that same edge is also dropped.
  - The next cycle has resp_valid=0. Requests accepted after that edge proceed normally.
- clear mid-operation:
  - In-flight responses are dropped, same as flush.
  - req_ready drops the cycle after the clear edge; init_done drops with it.
  - clear while already in INIT restarts cnt at 0.
- Async reset mid-stream: outputs go to reset values immediately, with no clock edge needed.
- Priority: rst_n > clear > flush > normal operation.

Test Plan:
- Release reset with DEPTH=8 -> req_ready=0 and init_done=0 for exactly 8 cycles, then 1; reading any address returns INIT_WORD.
- Write 0x1111..0x8888 to addresses 0..7, then read addr 6 with FETCH_W=2, LATENCY=2 -> resp_valid after 2 edges, resp_data={0x8888,0x7777}; read addr 7 -> {0x1111,0x8888} (wrap-around).
- Back-to-back requests to addr 0,2,4 on consecutive cycles, LATENCY=3 -> three consecutive resp_valid cycles in order, with data {0x2222,0x1111}, {0x4444,0x3333}, {0x6666,0x5555}.
- Same edge: write addr 3=0xABCD and read addr 3 -> response word0=0x4444 (old data); next read of addr 3 -> 0xABCD.
- Two requests in flight with LATENCY=3, flush pulsed -> no resp_valid for either; a request issued the cycle after the flush returns normally.
- clear pulsed with a request in flight -> no response, 8 INIT cycles, array reads INIT_WORD; wr_en during INIT has no effect.
- rst_n dropped asynchronously mid-cycle while resp_valid=1 -> resp_valid=0 immediately, without waiting for a clock edge.
